// File: rtl/imem_arbiter.sv
// Two-port (fetch/debug) round-robin arbiter in front of a synchronous instruction memory.
// Range-checks each relative address and returns a one-cycle response strobe per request.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | ready for the granted port, accepts one request
// S_ISSUE | mem_en high, mem_addr = latched addr + BASE_ADDR
// S_WAIT  | memory read in flight, mem_data captured at end of cycle
// S_RESP  | owner rsp_valid high for one cycle, then back to S_IDLE
module imem_arbiter #(
   parameter logic [31:0] BASE_ADDR = 32'd0,
   parameter logic [31:0] MEM_SIZE  = 32'd15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        f_req_valid,
   input  logic [31:0] f_req_addr,
   output logic        f_req_ready,
   output logic        f_rsp_valid,
   output logic [31:0] f_rsp_data,
   output logic        f_rsp_err,
   input  logic        d_req_valid,
   input  logic [31:0] d_req_addr,
   output logic        d_req_ready,
   output logic        d_rsp_valid,
   output logic [31:0] d_rsp_data,
   output logic        d_rsp_err,
   output logic        mem_en,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t      r_state;
   logic        r_owner_d;
   logic        r_last_d;
   logic        r_mem_en;
   logic [31:0] r_mem_addr;
   logic        r_f_rsp_valid;
   logic [31:0] r_f_rsp_data;
   logic        r_f_rsp_err;
   logic        r_d_rsp_valid;
   logic [31:0] r_d_rsp_data;
   logic        r_d_rsp_err;

   logic        w_idle;
   logic        w_grant_f;
   logic        w_grant_d;
   logic        w_accept;
   logic [31:0] w_addr;
   logic        w_in_range;

   // Fetch wins a tie only when debug was the last port served.
   assign w_idle     = (r_state == S_IDLE);
   assign w_grant_f  = f_req_valid && (!d_req_valid || r_last_d);
   assign w_grant_d  = d_req_valid && !w_grant_f;
   assign w_accept   = w_idle && (w_grant_f || w_grant_d);
   assign w_addr     = w_grant_d ? d_req_addr : f_req_addr;
   assign w_in_range = (w_addr <= MEM_SIZE);

   assign f_req_ready = w_idle && w_grant_f;
   assign d_req_ready = w_idle && w_grant_d;
   assign busy        = !w_idle;
   assign mem_en      = r_mem_en;
   assign mem_addr    = r_mem_addr;
   assign f_rsp_valid = r_f_rsp_valid;
   assign f_rsp_data  = r_f_rsp_data;
   assign f_rsp_err   = r_f_rsp_err;
   assign d_rsp_valid = r_d_rsp_valid;
   assign d_rsp_data  = r_d_rsp_data;
   assign d_rsp_err   = r_d_rsp_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_owner_d     <= 1'b0;
         r_last_d      <= 1'b1;
         r_mem_en      <= 1'b0;
         r_mem_addr    <= 32'd0;
         r_f_rsp_valid <= 1'b0;
         r_f_rsp_data  <= 32'd0;
         r_f_rsp_err   <= 1'b0;
         r_d_rsp_valid <= 1'b0;
         r_d_rsp_data  <= 32'd0;
         r_d_rsp_err   <= 1'b0;
      end else begin
         r_mem_en      <= 1'b0;
         r_f_rsp_valid <= 1'b0;
         r_d_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_owner_d <= w_grant_d;
                  r_last_d  <= w_grant_d;
                  if (w_in_range) begin
                     r_state    <= S_ISSUE;
                     r_mem_en   <= 1'b1;
                     r_mem_addr <= w_addr + BASE_ADDR;
                  end else begin
                     // Out-of-range requests skip the memory and answer next cycle.
                     r_state <= S_RESP;
                     if (w_grant_d) begin
                        r_d_rsp_valid <= 1'b1;
                        r_d_rsp_data  <= 32'd0;
                        r_d_rsp_err   <= 1'b1;
                     end else begin
                        r_f_rsp_valid <= 1'b1;
                        r_f_rsp_data  <= 32'd0;
                        r_f_rsp_err   <= 1'b1;
                     end
                  end
               end
            end
            S_ISSUE: r_state <= S_WAIT;
            S_WAIT: begin
               r_state <= S_RESP;
               if (r_owner_d) begin
                  r_d_rsp_valid <= 1'b1;
                  r_d_rsp_data  <= mem_data;
                  r_d_rsp_err   <= 1'b0;
               end else begin
                  r_f_rsp_valid <= 1'b1;
                  r_f_rsp_data  <= mem_data;
                  r_f_rsp_err   <= 1'b0;
               end
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: a default instance backed by a 16-word memory model,
// plus a BASE_ADDR = 32'hFFFFFFFF instance for address wrap.
module tb_imem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        f_req_valid, d_req_valid;
   logic [31:0] f_req_addr, d_req_addr;
   logic        f_req_ready, f_rsp_valid, f_rsp_err;
   logic        d_req_ready, d_rsp_valid, d_rsp_err;
   logic [31:0] f_rsp_data, d_rsp_data;
   logic        mem_en, busy;
   logic [31:0] mem_addr, mem_data;

   logic        w_f_req_valid, w_d_req_valid;
   logic [31:0] w_f_req_addr, w_d_req_addr;
   logic        w_f_req_ready, w_f_rsp_valid, w_f_rsp_err;
   logic        w_d_req_ready, w_d_rsp_valid, w_d_rsp_err;
   logic [31:0] w_f_rsp_data, w_d_rsp_data;
   logic        w_mem_en, w_busy;
   logic [31:0] w_mem_addr, w_mem_data;

   logic [31:0] mem [0:15];

   int n_chk;
   int n_bad;

   imem_arbiter u_dut (
      .clk(clk), .rst_n(rst_n),
      .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
      .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
      .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_req_ready),
      .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy)
   );

   imem_arbiter #(.BASE_ADDR(32'hFFFF_FFFF)) u_dut_wrap (
      .clk(clk), .rst_n(rst_n),
      .f_req_valid(w_f_req_valid), .f_req_addr(w_f_req_addr), .f_req_ready(w_f_req_ready),
      .f_rsp_valid(w_f_rsp_valid), .f_rsp_data(w_f_rsp_data), .f_rsp_err(w_f_rsp_err),
      .d_req_valid(w_d_req_valid), .d_req_addr(w_d_req_addr), .d_req_ready(w_d_req_ready),
      .d_rsp_valid(w_d_rsp_valid), .d_rsp_data(w_d_rsp_data), .d_rsp_err(w_d_rsp_err),
      .mem_en(w_mem_en), .mem_addr(w_mem_addr), .mem_data(w_mem_data), .busy(w_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memory: data valid the cycle after mem_en.
   always @(posedge clk) begin
      if (mem_en) mem_data <= mem[mem_addr[3:0]];
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      n_chk = 0;
      n_bad = 0;
      for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;
      mem[5] = 32'hDEAD_BEEF;
      mem_data    = 32'd0;
      w_mem_data  = 32'h0000_CAFE;
      rst_n       = 1'b0;
      f_req_valid = 1'b0; f_req_addr = 32'd0;
      d_req_valid = 1'b0; d_req_addr = 32'd0;
      w_f_req_valid = 1'b0; w_f_req_addr = 32'd0;
      w_d_req_valid = 1'b0; w_d_req_addr = 32'd0;

      // Reset state
      tick();
      check_eq("rst_busy",     busy, 0);
      check_eq("rst_mem_en",   mem_en, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_f_data",   f_rsp_data, 0);
      check_eq("rst_f_valid",  f_rsp_valid, 0);
      check_eq("rst_d_err",    d_rsp_err, 0);

      // Fetch addr 5 in range; wrap instance fetch addr 3
      rst_n = 1'b1;
      f_req_valid = 1'b1; f_req_addr = 32'd5;
      w_f_req_valid = 1'b1; w_f_req_addr = 32'd3;
      #1;
      check_eq("f5_ready",   f_req_ready, 1);
      check_eq("f5_d_ready", d_req_ready, 0);
      tick();
      f_req_valid = 1'b0; w_f_req_valid = 1'b0;
      check_eq("f5_mem_en",   mem_en, 1);
      check_eq("f5_mem_addr", mem_addr, 32'd5);
      check_eq("f5_busy",     busy, 1);
      check_eq("f5_ready_busy", f_req_ready, 0);
      check_eq("wrap_mem_en",   w_mem_en, 1);
      check_eq("wrap_mem_addr", w_mem_addr, 32'h0000_0002);
      tick();
      check_eq("f5_mem_en_off", mem_en, 0);
      check_eq("f5_early_rsp",  f_rsp_valid, 0);
      tick();
      check_eq("f5_rsp_valid", f_rsp_valid, 1);
      check_eq("f5_rsp_data",  f_rsp_data, 32'hDEAD_BEEF);
      check_eq("f5_rsp_err",   f_rsp_err, 0);
      check_eq("f5_d_valid",   d_rsp_valid, 0);
      check_eq("wrap_rsp_valid", w_f_rsp_valid, 1);
      check_eq("wrap_rsp_data",  w_f_rsp_data, 32'h0000_CAFE);
      tick();
      check_eq("f5_rsp_pulse", f_rsp_valid, 0);
      check_eq("f5_data_hold", f_rsp_data, 32'hDEAD_BEEF);
      check_eq("f5_idle",      busy, 0);
      check_eq("f5_addr_hold", mem_addr, 32'd5);

      // Debug addr 16 out of range
      d_req_valid = 1'b1; d_req_addr = 32'd16;
      #1;
      check_eq("d16_ready",   d_req_ready, 1);
      check_eq("d16_f_ready", f_req_ready, 0);
      tick();
      d_req_valid = 1'b0;
      check_eq("d16_rsp_valid", d_rsp_valid, 1);
      check_eq("d16_rsp_err",   d_rsp_err, 1);
      check_eq("d16_rsp_data",  d_rsp_data, 0);
      check_eq("d16_no_mem_en", mem_en, 0);
      check_eq("d16_busy",      busy, 1);
      check_eq("d16_f_hold",    f_rsp_data, 32'hDEAD_BEEF);
      tick();
      check_eq("d16_pulse",    d_rsp_valid, 0);
      check_eq("d16_err_hold", d_rsp_err, 1);
      check_eq("d16_idle",     busy, 0);

      // Debug addr 7 in flight while fetch addr 9 waits
      d_req_valid = 1'b1; d_req_addr = 32'd7;
      #1;
      check_eq("d7_ready", d_req_ready, 1);
      tick();
      d_req_valid = 1'b0;
      f_req_valid = 1'b1; f_req_addr = 32'd9;
      #1;
      check_eq("f9_wait_issue", f_req_ready, 0);
      check_eq("d7_mem_addr",   mem_addr, 32'd7);
      tick();
      check_eq("f9_wait_wait", f_req_ready, 0);
      tick();
      check_eq("d7_rsp_valid", d_rsp_valid, 1);
      check_eq("d7_rsp_data",  d_rsp_data, 32'hA000_0007);
      check_eq("d7_rsp_err",   d_rsp_err, 0);
      check_eq("f9_wait_resp", f_req_ready, 0);
      tick();
      check_eq("f9_ready_idle", f_req_ready, 1);
      tick();
      f_req_valid = 1'b0;
      check_eq("f9_mem_en",   mem_en, 1);
      check_eq("f9_mem_addr", mem_addr, 32'd9);
      tick();
      tick();
      check_eq("f9_rsp_valid", f_rsp_valid, 1);
      check_eq("f9_rsp_data",  f_rsp_data, 32'hA000_0009);
      check_eq("d7_data_hold", d_rsp_data, 32'hA000_0007);
      tick();

      // Reset, then both ports valid continuously: fetch wins first tie
      rst_n = 1'b0;
      #1;
      check_eq("rst2_f_data", f_rsp_data, 0);
      check_eq("rst2_d_data", d_rsp_data, 0);
      tick();
      rst_n = 1'b1;
      f_req_valid = 1'b1; f_req_addr = 32'd1;
      d_req_valid = 1'b1; d_req_addr = 32'd2;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_eq("rr_f_ready", f_req_ready, (k % 2 == 0) ? 1 : 0);
         check_eq("rr_d_ready", d_req_ready, (k % 2 == 0) ? 0 : 1);
         check_eq("rr_one_ready", {31'd0, f_req_ready & d_req_ready}, 0);
         tick();
         tick();
         tick();
         if (k % 2 == 0) begin
            check_eq("rr_f_rsp",   f_rsp_valid, 1);
            check_eq("rr_f_data",  f_rsp_data, 32'hA000_0001);
            check_eq("rr_d_quiet", d_rsp_valid, 0);
         end else begin
            check_eq("rr_d_rsp",   d_rsp_valid, 1);
            check_eq("rr_d_data",  d_rsp_data, 32'hA000_0002);
            check_eq("rr_f_quiet", f_rsp_valid, 0);
         end
         tick();
      end
      d_req_valid = 1'b0;

      // Reset during WAIT aborts the fetch of addr 4
      f_req_addr = 32'd4;
      tick();
      f_req_valid = 1'b0;
      tick();
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("abort_busy",     busy, 0);
      check_eq("abort_mem_en",   mem_en, 0);
      check_eq("abort_mem_addr", mem_addr, 0);
      check_eq("abort_f_data",   f_rsp_data, 0);
      tick();
      rst_n = 1'b1;
      check_eq("abort_no_rsp0", f_rsp_valid, 0);
      tick();
      check_eq("abort_no_rsp1", f_rsp_valid, 0);
      f_req_valid = 1'b1; f_req_addr = 32'd0;
      #1;
      check_eq("post_rst_ready", f_req_ready, 1);
      tick();
      f_req_valid = 1'b0;
      check_eq("post_rst_mem_en",   mem_en, 1);
      check_eq("post_rst_mem_addr", mem_addr, 32'd0);
      tick();
      tick();
      check_eq("post_rst_rsp",  f_rsp_valid, 1);
      check_eq("post_rst_data", f_rsp_data, 32'hA000_0000);
      check_eq("post_rst_err",  f_rsp_err, 0);
      tick();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
